// File: rtl/spi_rx.sv
// SPI receiver: oversamples SCK/MOSI/DC/CS in the clk domain, rebuilds MSB-first bytes tagged with DC.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry receive FIFO; otherwise a single holding register is used.
//
// state    | meaning
// ST_IDLE  | bit_cnt = 0, waiting for the first SCK rise of a byte
// ST_SHIFT | 1..7 bits of the current byte received
module spi_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       SCK,
  input  logic       MOSI,
  input  logic       DC,
  input  logic       CS,
  output logic [7:0] rx_data,
  output logic       rx_mode,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  input  logic       clr_ovr,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sr, mosi_sr, dc_sr, cs_sr;
  logic       sck_s, mosi_s, dc_s, cs_s, sck_d;
  logic       sck_rise, push, pop, full, ovr_set;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [8:0] push_word, head;
  logic [0:0] state;

  // CS resets high so a tied-low CS still needs SYNC_STAGES clocks before edges count
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_sr  <= '0;
      mosi_sr <= '0;
      dc_sr   <= '0;
      cs_sr   <= '1;
      sck_d   <= 1'b0;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], SCK};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
      dc_sr   <= {dc_sr[SYNC_STAGES-2:0], DC};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], CS};
      sck_d   <= sck_s;
    end
  end

  assign sck_s  = sck_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];
  assign dc_s   = dc_sr[SYNC_STAGES-1];
  assign cs_s   = cs_sr[SYNC_STAGES-1];

  assign sck_rise  = sck_s & ~sck_d & ~cs_s;
  assign push      = sck_rise & (bit_cnt == 3'd7);
  assign push_word = {dc_s, shreg, mosi_s};
  assign pop       = rx_valid & rx_ready;
  assign ovr_set   = push & full & ~pop;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
    end else if (cs_s) begin
      state   <= ST_IDLE;
      bit_cnt <= 3'd0;
    end else if (sck_rise) begin
      shreg   <= {shreg[5:0], mosi_s};
      bit_cnt <= bit_cnt + 3'd1;
      state   <= (bit_cnt == 3'd7) ? ST_IDLE : ST_SHIFT;
    end
  end

  assign busy = (state == ST_SHIFT);

`ifdef SPI_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [8:0]    last_q;
  logic          push_ok;

  assign full    = (count == DEPTH_C);
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
    end
  end

  // When empty, keep presenting the most recently consumed entry
  assign rx_valid = (count != '0);
  assign head     = rx_valid ? mem[rd_ptr] : last_q;
`else
  logic [8:0] hold_q;
  logic       valid_q;
  logic       unused_depth;

  assign unused_depth = ^FIFO_DEPTH;
  assign full         = valid_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push && (!valid_q || pop)) begin
      hold_q  <= push_word;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign rx_valid = valid_q;
  assign head     = hold_q;
`endif

  assign rx_data = head[7:0];
  assign rx_mode = head[8];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: table vectors, directed corner sequences and
// randomized bytes checked against a queue-based model of the receive buffer.
module tb_spi_rx;

  localparam int SYNC = 2;
`ifdef SPI_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk, nrst, SCK, MOSI, DC, CS, rx_ready, clr_ovr;
  logic [7:0] rx_data;
  logic       rx_mode, rx_valid, overrun, busy;

  int total = 0;
  int bad   = 0;

  logic [8:0] got [$];
  logic       mon_en = 1'b0;

  spi_rx #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .nrst(nrst), .SCK(SCK), .MOSI(MOSI), .DC(DC), .CS(CS),
    .rx_data(rx_data), .rx_mode(rx_mode), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .clr_ovr(clr_ovr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // consumer-side monitor: records every byte handed over
  always @(negedge clk) if (mon_en && rx_valid && rx_ready) got.push_back({rx_mode, rx_data});

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, input logic dc, input int half);
    for (int i = 0; i < n; i++) begin
      MOSI = d[7-i];
      DC   = dc;
      repeat (half) @(negedge clk);
      SCK = 1'b1;
      repeat (half) @(negedge clk);
      SCK = 1'b0;
    end
  endtask

  task automatic pop_check(input string name, input logic [8:0] exp);
    check({name, "_valid"}, rx_valid, 1);
    check({name, "_word"}, {rx_mode, rx_data}, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [8:0] exp_word;
  } vec_t;

  vec_t vecs [6];
  logic [8:0] q [$];
  logic [8:0] last_out;
  logic       movr;
  logic [7:0] d;
  logic       dcr;
  int         lat, k;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 9'h1A5};
    vecs[1] = '{8'h3C, 1'b0, 9'h03C};
    vecs[2] = '{8'hC3, 1'b1, 9'h1C3};
    vecs[3] = '{8'h00, 1'b0, 9'h000};
    vecs[4] = '{8'hFF, 1'b1, 9'h1FF};
    vecs[5] = '{8'h81, 1'b0, 9'h081};

    nrst = 1'b0; SCK = 1'b0; MOSI = 1'b0; DC = 1'b0; CS = 1'b0;
    rx_ready = 1'b0; clr_ovr = 1'b0;

    // reset held while the link toggles
    for (int i = 0; i < 8; i++) begin
      MOSI = ~MOSI;
      repeat (2) @(negedge clk); SCK = 1'b1;
      repeat (2) @(negedge clk); SCK = 1'b0;
    end
    check("rst_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_data", rx_data, 8'h00);
    nrst = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_valid", rx_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_data", rx_data, 8'h00);

    // single byte, latency and single handover
    got.delete(); mon_en = 1'b1; rx_ready = 1'b1;
    send_bits(8'hA5, 7, 1'b1, 4);
    MOSI = 1'b1;
    repeat (4) @(negedge clk);
    SCK = 1'b1;
    lat = 0;
    while (!rx_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("t2_latency_ok", (lat >= 1 && lat <= SYNC + 2), 1);
    repeat (4) @(negedge clk);
    SCK = 1'b0;
    repeat (8) @(negedge clk);
    check("t2_count", got.size(), 1);
    check("t2_word", got.size() > 0 ? got[0] : 9'h0, 9'h1A5);

    // back-to-back bytes with CS tied low
    got.delete();
    send_bits(8'h3C, 8, 1'b0, 4);
    send_bits(8'hC3, 8, 1'b1, 4);
    repeat (8) @(negedge clk);
    check("t3_count", got.size(), 2);
    check("t3_first", got.size() > 0 ? got[0] : 9'h0, 9'h03C);
    check("t3_second", got.size() > 1 ? got[1] : 9'h0, 9'h1C3);
    mon_en = 1'b0; rx_ready = 1'b0;

    // table vectors, one byte at a time
    for (int i = 0; i < 6; i++) begin
      send_bits(vecs[i].data, 8, vecs[i].dc, 4);
      repeat (4) @(negedge clk);
      pop_check($sformatf("vec%0d", i), vecs[i].exp_word);
      check($sformatf("vec%0d_empty", i), rx_valid, 0);
      check($sformatf("vec%0d_hold", i), rx_data, vecs[i].data);
    end

    // CS abort of a partial byte
    send_bits(8'hB0, 5, 1'b0, 4);
    check("t4_busy_mid", busy, 1);
    CS = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_busy_cs", busy, 0);
    CS = 1'b0;
    repeat (2) @(negedge clk);
    send_bits(8'h81, 8, 1'b0, 4);
    repeat (4) @(negedge clk);
    check("t4_ovr", overrun, 0);
    pop_check("t4", 9'h081);
    check("t4_empty", rx_valid, 0);

    // overflow: DEPTH+1 bytes with no consumer
    for (int i = 0; i <= DEPTH; i++) begin
      send_bits(8'((i + 1) * 17), 8, i[0], 4);
      repeat (4) @(negedge clk);
      if (i == DEPTH - 1) check("t5_no_ovr_yet", overrun, 0);
    end
    check("t5_ovr", overrun, 1);
    check("t5_head", rx_data, 8'h11);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("t5_clr", overrun, 0);
    // another dropped byte with clr_ovr in the very cycle it is dropped
    send_bits(8'hEE, 7, 1'b1, 4);
    MOSI = 1'b0;
    repeat (4) @(negedge clk);
    SCK = 1'b1;
    repeat (SYNC) @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    repeat (3) @(negedge clk);
    SCK = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_set_wins", overrun, 1);
    for (int i = 0; i < DEPTH; i++)
      pop_check($sformatf("t5_keep%0d", i), {i[0], 8'((i + 1) * 17)});
    check("t5_empty", rx_valid, 0);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    check("t5_clr2", overrun, 0);

    // reset mid-byte
    send_bits(8'hF0, 4, 1'b0, 4);
    nrst = 1'b0;
    #1;
    check("t6_valid", rx_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_ovr", overrun, 0);
    check("t6_data", rx_data, 8'h00);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    send_bits(8'h5A, 8, 1'b1, 4);
    repeat (4) @(negedge clk);
    pop_check("t6_after", 9'h15A);

    // randomized bytes against the buffer model
    movr = 1'b0;
    last_out = 9'h15A;
    for (int it = 0; it < 30; it++) begin
      d   = 8'($urandom);
      dcr = 1'($urandom);
      send_bits(d, 8, dcr, $urandom_range(2, 5));
      repeat (4) @(negedge clk);
      if (q.size() < DEPTH) q.push_back({dcr, d});
      else movr = 1'b1;
      check($sformatf("rnd%0d_ovr", it), overrun, movr);
      check($sformatf("rnd%0d_valid", it), rx_valid, q.size() != 0);
      k = $urandom_range(0, q.size());
      for (int j = 0; j < k; j++) begin
        last_out = q.pop_front();
        pop_check($sformatf("rnd%0d_pop%0d", it, j), last_out);
      end
      if (q.size() == 0) check($sformatf("rnd%0d_hold", it), {rx_mode, rx_data}, last_out);
      if ($urandom_range(0, 3) == 0) begin
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        movr = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
